// File: rtl/dg0045_pkg.sv
// Shared types and constants for the DG0045 program-memory responder.
package dg0045_pkg;

    localparam int DG_PC_W = 10;
    localparam int DG_HL_W = 5;

    localparam logic [7:0] DG_NOP = 8'h00;

    typedef enum logic [2:0] {
        ST_LO     = 3'd0,
        ST_HI     = 3'd1,
        ST_LO_CHK = 3'd2,
        ST_LOOKUP = 3'd3,
        ST_IDLE   = 3'd4
    } scan_state_t;

endpackage

// File: rtl/dg0045_prog_store.sv
// Program store: synchronous write, asynchronous read; out-of-range reads return NOP
// and out-of-range writes are dropped.
module dg0045_prog_store
    import dg0045_pkg::*;
#(
    parameter int ROM_DEPTH = 64
) (
    input  logic               clk_in,
    input  logic               we,
    input  logic [DG_PC_W-1:0] waddr,
    input  logic [7:0]         wdata,
    input  logic [DG_PC_W-1:0] raddr,
    output logic [7:0]         rdata
);

    localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam logic [DG_PC_W:0] DEPTH_L = (DG_PC_W + 1)'(ROM_DEPTH);

    logic [7:0] mem [ROM_DEPTH];
    logic       w_in_range;
    logic       r_in_range;

    assign w_in_range = ({1'b0, waddr} < DEPTH_L);
    assign r_in_range = ({1'b0, raddr} < DEPTH_L);

    always_ff @(posedge clk_in) begin
        if (we && w_in_range) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = r_in_range ? mem[raddr[AW-1:0]] : DG_NOP;

endmodule

// File: rtl/dg0045_rom_responder.sv
// Scans the core's multiplexed PC, looks the address up in the program store and
// presents the instruction byte; a host load port writes the store while fetch is idle.
//
//   state     | meaning
//   ST_LO     | pc_mux=0, sample PL[4:0] into lo
//   ST_HI     | pc_mux=1, sample {PU, PL[5]} into hi
//   ST_LO_CHK | pc_mux=0, resample PL[4:0] into lo2
//   ST_LOOKUP | accept scan if lo2==lo, update outputs
//   ST_IDLE   | fetch suspended, load port open, rom_data=NOP
module dg0045_rom_responder
    import dg0045_pkg::*;
#(
    parameter int ROM_DEPTH = 64,
    parameter int SETTLE    = 0
) (
    input  logic               clk_in,
    input  logic               RESET,
    input  logic [DG_HL_W-1:0] pc_hl,
    output logic               pc_mux,
    output logic [7:0]         rom_data,
    output logic [DG_PC_W-1:0] fetch_addr,
    output logic               fetch_stb,
    input  logic               prog_en,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [DG_PC_W-1:0] load_addr,
    input  logic [7:0]         load_data
);

    localparam int CW = $clog2(SETTLE + 2);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);

    scan_state_t        state;
    scan_state_t        state_nxt;
    logic [CW-1:0]      settle_cnt;
    logic               last_cyc;
    logic [DG_HL_W-1:0] lo;
    logic [DG_HL_W-1:0] hi;
    logic [DG_HL_W-1:0] lo2;
    logic               first_scan;
    logic               scan_ok;
    logic [DG_PC_W-1:0] scan_addr;
    logic [7:0]         mem_rdata;
    logic               store_we;

    assign last_cyc  = (settle_cnt == '0);
    assign scan_ok   = (lo2 == lo);
    assign scan_addr = {hi, lo};
    assign store_we  = load_valid & load_ready;

    dg0045_prog_store #(
        .ROM_DEPTH(ROM_DEPTH)
    ) u_store (
        .clk_in(clk_in),
        .we    (store_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (scan_addr),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_nxt  = state;
        load_ready = (state == ST_IDLE);
        case (state)
            ST_LO:     if (last_cyc) state_nxt = ST_HI;
            ST_HI:     if (last_cyc) state_nxt = ST_LO_CHK;
            ST_LO_CHK: if (last_cyc) state_nxt = ST_LOOKUP;
            ST_LOOKUP: state_nxt = ST_LO;
            ST_IDLE:   state_nxt = ST_LO;
            default:   state_nxt = ST_LO;
        endcase
        if (prog_en) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk_in or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_LO;
            settle_cnt <= SETTLE_LD;
            pc_mux     <= 1'b0;
            lo         <= '0;
            hi         <= '0;
            lo2        <= '0;
            rom_data   <= DG_NOP;
            fetch_addr <= '0;
            fetch_stb  <= 1'b0;
            first_scan <= 1'b1;
        end else begin
            state     <= state_nxt;
            pc_mux    <= (state_nxt == ST_HI);
            fetch_stb <= 1'b0;

            // Reload the settle timer on every state change; it holds at zero otherwise.
            if (state_nxt != state) begin
                settle_cnt <= SETTLE_LD;
            end else if (!last_cyc) begin
                settle_cnt <= settle_cnt - 1'b1;
            end

            case (state)
                ST_LO:     if (last_cyc) lo  <= pc_hl;
                ST_HI:     if (last_cyc) hi  <= pc_hl;
                ST_LO_CHK: if (last_cyc) lo2 <= pc_hl;
                ST_LOOKUP: begin
                    if (!prog_en && scan_ok) begin
                        rom_data <= mem_rdata;
                        if (first_scan || (scan_addr != fetch_addr)) begin
                            fetch_addr <= scan_addr;
                            fetch_stb  <= 1'b1;
                            first_scan <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase

            // Entering or sitting in IDLE blanks the byte and re-arms the first-scan pulse.
            if (state_nxt == ST_IDLE) begin
                rom_data   <= DG_NOP;
                first_scan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dg0045_rom_responder.sv
// Self-checking bench: core PC model on pc_hl, vector table plus corner sequences,
// and a scoreboard queue checked on every fetch_stb.
module tb_dg0045_rom_responder;

    logic       clk_in = 1'b0;
    logic       RESET;
    logic [4:0] pc_hl;
    logic       pc_mux;
    logic [7:0] rom_data;
    logic [9:0] fetch_addr;
    logic       fetch_stb;
    logic       prog_en;
    logic       load_valid;
    logic       load_ready;
    logic [9:0] load_addr;
    logic [7:0] load_data;

    logic [9:0] core_pc;

    int n_tests = 0;
    int n_fail  = 0;
    int stb_count = 0;
    logic [17:0] exp_q [$];
    logic [17:0] mon_e;

    typedef struct {
        logic [9:0] pc;
        logic [7:0] exp_data;
        bit         exp_stb;
    } vec_t;
    vec_t vecs [7];

    always #5 clk_in = ~clk_in;

    // Core model: low half when pc_mux=0, {PU, PL[5]} when pc_mux=1.
    assign pc_hl = pc_mux ? core_pc[9:5] : core_pc[4:0];

    dg0045_rom_responder #(
        .ROM_DEPTH(64),
        .SETTLE   (0)
    ) dut (
        .clk_in    (clk_in),
        .RESET     (RESET),
        .pc_hl     (pc_hl),
        .pc_mux    (pc_mux),
        .rom_data  (rom_data),
        .fetch_addr(fetch_addr),
        .fetch_stb (fetch_stb),
        .prog_en   (prog_en),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic wait_hi(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (pc_mux === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic load_one(input logic [9:0] a, input logic [7:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        chk("load_ready", load_ready, 1);
        @(negedge clk_in);
    endtask

    always @(negedge clk_in) begin
        if (RESET === 1'b1 && fetch_stb === 1'b1) begin
            stb_count++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL stb_unexpected: got pulse at addr %0h, expected none", fetch_addr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("stb_addr", fetch_addr, mon_e[17:8]);
                chk("stb_data", rom_data, mon_e[7:0]);
            end
        end
    end

    initial begin
        bit ok;
        int s0;

        vecs[0] = '{pc: 10'h3E1, exp_data: 8'h00, exp_stb: 1'b1};
        vecs[1] = '{pc: 10'h3E1, exp_data: 8'h00, exp_stb: 1'b0};
        vecs[2] = '{pc: 10'h001, exp_data: 8'h11, exp_stb: 1'b1};
        vecs[3] = '{pc: 10'h03F, exp_data: 8'h5A, exp_stb: 1'b1};
        vecs[4] = '{pc: 10'h021, exp_data: 8'hC3, exp_stb: 1'b1};
        vecs[5] = '{pc: 10'h040, exp_data: 8'h00, exp_stb: 1'b1};
        vecs[6] = '{pc: 10'h000, exp_data: 8'h4C, exp_stb: 1'b1};

        RESET      = 1'b0;
        prog_en    = 1'b1;
        load_valid = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        core_pc    = '0;

        cycles(3);
        chk("rst_pc_mux", pc_mux, 0);
        chk("rst_rom_data", rom_data, 0);
        chk("rst_fetch_addr", fetch_addr, 0);
        chk("rst_fetch_stb", fetch_stb, 0);
        chk("rst_load_ready", load_ready, 0);

        RESET = 1'b1;
        cycles(1);
        chk("idle_load_ready", load_ready, 1);
        chk("idle_rom_data", rom_data, 0);

        load_one(10'h000, 8'h4C);
        load_one(10'h005, 8'hA7);
        load_one(10'h001, 8'h11);
        load_one(10'h03F, 8'h5A);
        load_one(10'h021, 8'hC3);
        load_one(10'h040, 8'hFF);
        load_valid = 1'b0;

        core_pc = 10'h005;
        prog_en = 1'b0;
        exp_q.push_back({10'h005, 8'hA7});
        s0 = stb_count;
        cycles(12);
        chk("first_rom_data", rom_data, 8'hA7);
        chk("first_fetch_addr", fetch_addr, 10'h005);
        chk("first_stb_count", stb_count - s0, 1);
        chk("run_load_ready", load_ready, 0);

        for (int i = 0; i < 7; i++) begin
            core_pc = vecs[i].pc;
            if (vecs[i].exp_stb) exp_q.push_back({vecs[i].pc, vecs[i].exp_data});
            s0 = stb_count;
            cycles(12);
            chk("vec_rom_data", rom_data, vecs[i].exp_data);
            chk("vec_fetch_addr", fetch_addr, vecs[i].pc);
            chk("vec_stb_count", stb_count - s0, vecs[i].exp_stb);
        end

        // Torn scan: PL changes while the HI half is being sampled.
        core_pc = 10'h005;
        exp_q.push_back({10'h005, 8'hA7});
        cycles(12);
        wait_hi(ok);
        chk("torn_wait_hi", ok, 1);
        core_pc = 10'h000;
        exp_q.push_back({10'h000, 8'h4C});
        s0 = stb_count;
        cycles(4);
        chk("torn_no_stb", stb_count - s0, 0);
        chk("torn_fetch_addr", fetch_addr, 10'h005);
        cycles(8);
        chk("after_torn_addr", fetch_addr, 10'h000);
        chk("after_torn_data", rom_data, 8'h4C);
        chk("after_torn_stb", stb_count - s0, 1);

        // Rewrite the currently fetched byte; first scan after resume pulses.
        prog_en = 1'b1;
        cycles(1);
        chk("prog_rom_data", rom_data, 0);
        load_one(10'h000, 8'h99);
        load_valid = 1'b0;
        prog_en = 1'b0;
        exp_q.push_back({10'h000, 8'h99});
        s0 = stb_count;
        cycles(12);
        chk("reload_data", rom_data, 8'h99);
        chk("reload_stb", stb_count - s0, 1);

        // Reset in the middle of HI; address 0 matches the reset fetch_addr.
        core_pc = 10'h005;
        exp_q.push_back({10'h005, 8'hA7});
        cycles(12);
        wait_hi(ok);
        chk("rst_wait_hi", ok, 1);
        RESET = 1'b0;
        #1;
        chk("midrst_pc_mux", pc_mux, 0);
        chk("midrst_fetch_addr", fetch_addr, 0);
        chk("midrst_rom_data", rom_data, 0);
        chk("midrst_fetch_stb", fetch_stb, 0);
        core_pc = 10'h000;
        exp_q.push_back({10'h000, 8'h99});
        s0 = stb_count;
        cycles(2);
        RESET = 1'b1;
        cycles(12);
        chk("postrst_stb", stb_count - s0, 1);
        chk("postrst_addr", fetch_addr, 10'h000);
        chk("postrst_data", rom_data, 8'h99);

        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
